// File: rtl/simple_processor_pkg.sv
// Shared processor types and constants; holds the data-memory responder state
// encoding and its sizing limits.
package simple_processor_pkg;

    localparam int ADDR_WIDTH         = 16;
    localparam int DATA_WIDTH         = 16;
    localparam int DMEM_DEFAULT_DEPTH = 256;
    localparam int DMEM_MAX_WAIT      = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dmem_state_t;

    // Number of low address bits that select a byte within one word.
    function automatic int dmem_offset_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with synchronous write and registered read; kept as
// its own module so it can be swapped for a memory macro.
module dmem_array #(
    parameter int MEM_DEPTH  = 256,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage is deliberately not reset; only the read register follows enables.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory req/ack responder: one request at a time, programmable wait, then
// a one-cycle ack. Optional err_o output when DMEM_RESPONDER_ERR_EN is defined.
module dmem_responder
    import simple_processor_pkg::*;
#(
    parameter int ADDR_WIDTH  = simple_processor_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = simple_processor_pkg::DATA_WIDTH,
    parameter int MEM_DEPTH   = DMEM_DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  ack_o
`ifdef DMEM_RESPONDER_ERR_EN
    ,
    output logic                  err_o
`endif
);

    localparam int OFF_W = dmem_offset_bits(DATA_WIDTH);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(DMEM_MAX_WAIT + 1);

    dmem_state_t           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] word_idx_s;
    logic                  in_range_s;
    logic                  ok_s;
    logic                  mem_we_s;
    logic                  mem_re_s;
    logic [DATA_WIDTH-1:0] mem_rdata_s;

    assign word_idx_s = addr_q >> OFF_W;
    assign in_range_s = (word_idx_s < ADDR_WIDTH'(MEM_DEPTH));

`ifdef DMEM_RESPONDER_ERR_EN
    logic misalign_s;
    assign misalign_s = ((addr_q & ADDR_WIDTH'((1 << OFF_W) - 1)) != '0);
    assign ok_s       = in_range_s & ~misalign_s;
    assign err_o      = err_q;
`else
    assign ok_s       = in_range_s;
`endif

    dmem_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk_i  (clk_i),
        .we_i   (mem_we_s),
        .re_i   (mem_re_s),
        .idx_i  (word_idx_s[IDX_W-1:0]),
        .wdata_i(wdata_q),
        .rdata_o(mem_rdata_s)
    );

    // Next-state and registered-output logic; the array is accessed in ACCESS
    // and its registered word is picked up in RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        mem_we_s = 1'b0;
        mem_re_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    we_d    = we_i;
                    wdata_d = wdata_i;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // A zero count can only come from corruption; leave WAIT anyway.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ACCESS;
                end else begin
                    state_d = WAIT;
                end
            end
            ACCESS: begin
                mem_we_s = we_q & ok_s;
                mem_re_s = ~we_q;
                state_d  = RESP;
            end
            RESP: begin
                ack_d = 1'b1;
                err_d = ~ok_s;
                if (!we_q) begin
                    rdata_d = ok_s ? mem_rdata_s : '0;
                end else begin
                    rdata_d = rdata_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured request and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign rdata_o = rdata_q;
    assign ack_o   = ack_q;

`ifndef DMEM_RESPONDER_ERR_EN
    logic unused_s;
    assign unused_s = err_q;
`endif

endmodule
